ifu32_fetch: RTL and testbench
==============================

// Module: ifu32_fetch
// PURPOSE
//  Instruction fetch stage, directly upstream of the RV32IM decoder.
//  Holds the PC, issues one word read at a time to instruction memory, and buffers the returned word.
//  Presents the word to decode with a valid/ready handshake, together with pre-split fields:
//  opcode[6:0], funct3 zero-extended to 4b, funct7 zero-extended to 8b.
//  Accepts PC redirects from execute and discards any stale response.
// PARAMETERS
//  RESET_PC  32'h8000_0000  PC loaded on reset
//  PC_STEP   4              sequential increment in bytes
// PORTS
//  clk             in   1   single clock, rising edge
//  rst_n           in   1   asynchronous assert, active-low reset
//  redirect_valid  in   1   execute requests PC change (branch/jump/trap)
//  redirect_pc     in   32  target PC
//  imem_req_valid  out  1   read request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  32  word address = pc
//  imem_rsp_valid  in   1   read data valid (always accepted; no rsp_ready)
//  imem_rsp_data   in   32  instruction word
//  imem_rsp_err    in   1   access fault on this response
//  out_valid       out  1   instruction available to decode
//  out_ready       in   1   decode consumes
//  out_pc          out  32  PC of out_inst
//  out_inst        out  32  instruction word
//  out_opcode      out  7   out_inst[6:0]
//  out_funct3      out  4   {1'b0, out_inst[14:12]}
//  out_funct7      out  8   {1'b0, out_inst[31:25]}
//  out_fault       out  1   fetch fault (rsp_err, or misaligned pc[1:0]!=0)
// BEHAVIOUR
//  Reset (async): pc=RESET_PC; state=S_REQ; out_valid=0; out_inst=0; out_pc=0; out_fault=0.
//  Field outputs are combinational slices of the out_inst register.
//  One outstanding request maximum. 4 states:
//   S_REQ : imem_req_valid = !redirect_valid && pc[1:0]==0.
//           req handshake -> S_WAIT.
//           pc[1:0]!=0 -> load out buffer with fault=1, inst=0 -> S_FULL; no memory access.
//   S_WAIT: rsp_valid -> latch data/err/pc into out buffer, out_valid=1 next cycle -> S_FULL.
//   S_FULL: out_valid=1, buffer stable until out_ready.
//           out_ready -> pc=pc+PC_STEP, out_valid=0 -> S_REQ.
//   S_DROP: rsp_valid -> discard -> S_REQ.
//  Redirect (highest priority, any state): pc<=redirect_pc next cycle; out_valid=0 next cycle.
//   S_REQ : no request issues this cycle; stay S_REQ.
//   S_WAIT: with rsp_valid same cycle -> discard, S_REQ; else -> S_DROP.
//   S_DROP: stay S_DROP (pending rsp still owed); with rsp_valid same cycle -> S_REQ.
//   S_FULL: buffer dropped even if out_ready same cycle; -> S_REQ.
//  Latency:
//   - first imem_req_valid in the first cycle after rst_n deasserts;
//   - out_valid 1 cycle after rsp_valid;
//   - next request 1 cycle after out handshake.
//  Arithmetic: pc+PC_STEP wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000), no flag.
//  rst_n assert mid-transaction: all state cleared.
//   Memory must not return a response after reset; any rsp_valid in S_REQ is ignored.
//  imem_req_addr = pc at all times; it is stable while imem_req_valid && !imem_req_ready.
// STRUCTURE
//  Package fetch_pkg:
//   - state encoding S_REQ/S_WAIT/S_FULL/S_DROP (2b);
//   - RESET_PC default;
//   - field slice localparams (OPC 6:0, F3 14:12, F7 31:25).
//   The decoder's opcode constants move into the same package.
//  Single flat module; no sub-module.
//  Output buffer is one register set {pc, inst, fault}.
// TESTING
//  1. Reset release, req_ready=1, 1-cycle memory returning 0x00000013, out_ready=1:
//     addr 0x80000000, then 0x80000004; out_opcode=7'h13, funct3=4'h0.
//  2. out_ready=0 for 5 cycles with out_valid=1: out_inst/out_pc constant, no new imem request;
//     out_ready=1 -> next addr = pc+4.
//  3. Redirect to 0x80000100 in S_WAIT, rsp arrives 3 cycles later with 0xDEADBEEF:
//     word never presented; next request addr 0x80000100.
//  4. Redirect same cycle as out_ready in S_FULL: no double advance; next addr = redirect_pc.
//  5. Redirect to 0x80000102: no request issued; out_valid=1, out_fault=1, out_pc=0x80000102.
//     imem_rsp_err=1 on a normal fetch: out_fault=1.
//  6. Assert rst_n=0 while in S_WAIT: out_valid=0 immediately;
//     after release, request restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch/decode encodings: FSM states, reset PC, field slices, opcodes
package fetch_pkg;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  localparam int OPC_HI = 6;
  localparam int OPC_LO = 0;
  localparam int F3_HI  = 14;
  localparam int F3_LO  = 12;
  localparam int F7_HI  = 31;
  localparam int F7_LO  = 25;

  // RV32IM major opcodes, shared with the decoder
  localparam logic [6:0] OPC_LOAD     = 7'h03;
  localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
  localparam logic [6:0] OPC_OP_IMM   = 7'h13;
  localparam logic [6:0] OPC_AUIPC    = 7'h17;
  localparam logic [6:0] OPC_STORE    = 7'h23;
  localparam logic [6:0] OPC_OP       = 7'h33;
  localparam logic [6:0] OPC_LUI      = 7'h37;
  localparam logic [6:0] OPC_BRANCH   = 7'h63;
  localparam logic [6:0] OPC_JALR     = 7'h67;
  localparam logic [6:0] OPC_JAL      = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM   = 7'h73;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } fetch_buf_t;

endpackage

// File: rtl/ifu32_fetch.sv
// rtl/ifu32_fetch.sv - single-outstanding instruction fetch stage with output buffer and redirect
module ifu32_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [6:0]  out_opcode,
  output logic [3:0]  out_funct3,
  output logic [7:0]  out_funct7,
  output logic        out_fault
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  fetch_buf_t  buf_q, buf_d;
  logic        pc_aligned;

  assign pc_aligned     = (pc_q[1:0] == 2'b00);
  assign imem_req_valid = (state_q == S_REQ) && !redirect_valid && pc_aligned;
  assign imem_req_addr  = pc_q;

  assign out_valid  = (state_q == S_FULL);
  assign out_pc     = buf_q.pc;
  assign out_inst   = buf_q.inst;
  assign out_fault  = buf_q.fault;
  assign out_opcode = buf_q.inst[OPC_HI:OPC_LO];
  assign out_funct3 = {1'b0, buf_q.inst[F3_HI:F3_LO]};
  assign out_funct7 = {1'b0, buf_q.inst[F7_HI:F7_LO]};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
      // An in-flight response is still owed; park in S_DROP until it arrives.
      case (state_q)
        S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
        S_DROP:  state_d = imem_rsp_valid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (!pc_aligned) begin
            buf_d   = '{pc: pc_q, inst: 32'h0, fault: 1'b1};
            state_d = S_FULL;
          end else if (imem_req_ready) begin
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            buf_d   = '{pc: pc_q, inst: imem_rsp_data, fault: imem_rsp_err};
            state_d = S_FULL;
          end
        end
        S_FULL: begin
          if (out_ready) begin
            pc_d    = pc_q + PC_STEP;
            state_d = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rsp_valid) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_ifu32_fetch.sv
// tb/tb_ifu32_fetch.sv - scoreboard bench for ifu32_fetch with a latency-programmable memory model
module tb_ifu32_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
    logic [6:0]  opc;
    logic [3:0]  f3;
    logic [7:0]  f7;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        imem_rsp_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [6:0]  out_opcode;
  logic [3:0]  out_funct3;
  logic [7:0]  out_funct7;
  logic        out_fault;

  int          n_vec = 0;
  int          n_err = 0;
  exp_t        out_q[$];
  logic [31:0] addr_q[$];
  int          rsp_delay = 1;
  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;

  ifu32_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h8000_0008: return 32'h40B5_0533;
      32'h8000_000C: return 32'hDEAD_BEEF;
      32'h8000_0100: return 32'h02C5_C6B3;
      32'h8000_0200: return 32'hFFF0_0093;
      32'h8000_0300: return 32'h0000_A003;
      32'hFFFF_FFFC: return 32'h0000_8067;
      default:       return 32'h0000_0013;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  task automatic push_out(input logic [31:0] pc, input logic [31:0] inst, input logic fault,
                          input logic [6:0] opc, input logic [3:0] f3, input logic [7:0] f7);
    exp_t e;
    e.pc = pc; e.inst = inst; e.fault = fault; e.opc = opc; e.f3 = f3; e.f7 = f7;
    out_q.push_back(e);
  endtask

  // Memory model: responds rsp_delay cycles after each accepted request; also checks request addresses.
  initial begin : mem_model
    forever begin
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      imem_rsp_err   = 1'b0;
      if (!rst_n) begin
        mem_busy = 1'b0;
      end else if (mem_busy) begin
        if (mem_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(mem_addr);
          imem_rsp_err   = (mem_addr == 32'h8000_0300);
          mem_busy       = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
      #2;
      if (rst_n && imem_req_valid && imem_req_ready) begin
        if (addr_q.size() == 0) begin
          fail_now($sformatf("unexpected_req addr=%h", imem_req_addr));
        end else begin
          chk("req_addr", imem_req_addr, addr_q.pop_front());
        end
        if (mem_busy) fail_now("second_outstanding_req");
        mem_busy = 1'b1;
        mem_cnt  = rsp_delay - 1;
        mem_addr = imem_req_addr;
      end
    end
  end

  initial begin : out_monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid && out_ready && !redirect_valid) begin
        if (out_q.size() == 0) begin
          fail_now($sformatf("unexpected_out pc=%h inst=%h", out_pc, out_inst));
        end else begin
          e = out_q.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_inst", out_inst, e.inst);
          chk("out_fault", 32'(out_fault), 32'(e.fault));
          chk("out_opcode", 32'(out_opcode), 32'(e.opc));
          chk("out_funct3", 32'(out_funct3), 32'(e.f3));
          chk("out_funct7", 32'(out_funct7), 32'(e.f7));
        end
      end
    end
  end

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail_now("out_valid_timeout");
  endtask

  task automatic consume();
    wait_valid();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin : stim
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_fault", 32'(out_fault), 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h8000_0000);

    // 1: two sequential NOP fetches
    addr_q.push_back(32'h8000_0000);
    addr_q.push_back(32'h8000_0004);
    addr_q.push_back(32'h8000_0008);
    push_out(32'h8000_0000, 32'h0000_0013, 1'b0, 7'h13, 4'h0, 8'h00);
    push_out(32'h8000_0004, 32'h0000_0013, 1'b0, 7'h13, 4'h0, 8'h00);
    push_out(32'h8000_0008, 32'h40B5_0533, 1'b0, 7'h33, 4'h0, 8'h20);
    rst_n = 1'b1;
    consume();
    consume();

    // 2: back-pressure holds the buffer and blocks new requests
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("stall_pc", out_pc, 32'h8000_0008);
      chk("stall_inst", out_inst, 32'h40B5_0533);
      chk("stall_no_req", 32'(imem_req_valid), 32'h0);
      @(negedge clk);
    end
    rsp_delay = 3;
    addr_q.push_back(32'h8000_000C);
    consume();

    // 3: redirect while waiting; late response must be discarded
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    addr_q.push_back(32'h8000_0100);
    @(negedge clk);
    redirect_valid = 1'b0;
    rsp_delay      = 1;
    wait_valid();
    chk("redir_out_pc", out_pc, 32'h8000_0100);
    chk("redir_out_inst", out_inst, 32'h02C5_C6B3);
    chk("redir_funct3", 32'(out_funct3), 32'h4);
    chk("redir_funct7", 32'(out_funct7), 32'h1);

    // 4: redirect coincides with out_ready in S_FULL
    addr_q.push_back(32'h8000_0200);
    push_out(32'h8000_0200, 32'hFFF0_0093, 1'b0, 7'h13, 4'h0, 8'h7F);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    @(negedge clk);
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    chk("drop_out_valid", 32'(out_valid), 32'h0);
    consume();

    // 5: misaligned redirect faults without a memory access, then a bus error
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    push_out(32'h8000_0102, 32'h0, 1'b1, 7'h00, 4'h0, 8'h00);
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("misalign_no_req", 32'(imem_req_valid), 32'h0);
    consume();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    addr_q.push_back(32'h8000_0300);
    push_out(32'h8000_0300, 32'h0000_A003, 1'b1, 7'h03, 4'h2, 8'h00);
    @(negedge clk);
    redirect_valid = 1'b0;
    consume();

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    addr_q.push_back(32'hFFFF_FFFC);
    push_out(32'hFFFF_FFFC, 32'h0000_8067, 1'b0, 7'h67, 4'h0, 8'h00);
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_valid();
    rsp_delay = 3;
    addr_q.push_back(32'h0000_0000);
    consume();

    // 6: reset while a request is outstanding
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    chk("midrst_req_addr", imem_req_addr, 32'h8000_0000);
    repeat (2) @(negedge clk);
    rsp_delay = 1;
    addr_q.push_back(32'h8000_0000);
    addr_q.push_back(32'h8000_0004);
    push_out(32'h8000_0000, 32'h0000_0013, 1'b0, 7'h13, 4'h0, 8'h00);
    rst_n = 1'b1;
    consume();
    wait_valid();
    repeat (3) @(negedge clk);
    chk("end_out_valid", 32'(out_valid), 32'h1);
    chk("end_out_pc", out_pc, 32'h8000_0004);
    chk("end_addr_q_empty", 32'(addr_q.size()), 32'h0);
    chk("end_out_q_empty", 32'(out_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
